// File: rtl/fetch_pkg.sv
// Shared widths and the queued {pc, instr} entry type for the instruction fetch queue.
package fetch_pkg;
  localparam int ADDR_W  = 13;
  localparam int INSTR_W = 16;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_queue_if.sv
// PC / instruction-memory / decode signal bundle around the fetch queue.
interface instr_fetch_queue_if;
  import fetch_pkg::*;

  logic               start;
  logic               flush;
  logic [ADDR_W-1:0]  pc_addr;
  logic [INSTR_W-1:0] mem_rdata;
  logic               stall_pc;
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc;

  modport master (
    output start, flush, pc_addr, mem_rdata, dec_ready,
    input  stall_pc, dec_valid, dec_instr, dec_pc
  );
  modport slave (
    input  start, flush, pc_addr, mem_rdata, dec_ready,
    output stall_pc, dec_valid, dec_instr, dec_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// DEPTH-entry circular buffer of fetch entries with occupancy count and synchronous clear.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t rdata,
  output logic [CW-1:0] count
);
  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wptr, rptr;

  assign rdata = mem[rptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= wdata;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
endmodule

// File: rtl/instr_fetch_queue.sv
// Tracks PC-issued fetches, captures read data a cycle later and queues {pc, instr} for decode.
// Optional FETCH_BYPASS_EN: forward the arriving word straight to decode when the queue is empty.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input logic               clk,
  input logic               reset,
  instr_fetch_queue_if.slave fq
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_L = DEPTH[CW:0];

  logic               inflight_valid;
  logic [ADDR_W-1:0]  inflight_addr;
  logic [CW-1:0]      count;
  logic [CW:0]        occ;
  logic               clr, fifo_empty, push, pop, take;
  fetch_entry_t       head, wdata, live, held;

  assign clr        = fq.flush | ~fq.start;
  assign fifo_empty = (count == '0);
  assign wdata      = '{pc: inflight_addr, instr: fq.mem_rdata};

  // Stall counts the in-flight word as occupied so its push can never overflow.
  assign occ         = {1'b0, count} + {{CW{1'b0}}, inflight_valid};
  assign fq.stall_pc = fq.start & (occ >= DEPTH_L);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inflight_valid <= 1'b0;
      inflight_addr  <= '0;
    end else begin
      inflight_valid <= fq.start & ~fq.flush & ~fq.stall_pc;
      inflight_addr  <= fq.pc_addr;
    end
  end

`ifdef FETCH_BYPASS_EN
  logic bypass;
  assign bypass       = fifo_empty & inflight_valid & ~clr;
  assign take         = bypass & fq.dec_ready;
  assign fq.dec_valid = ~clr & (~fifo_empty | bypass);
  assign live         = bypass ? wdata : head;
`else
  assign take         = 1'b0;
  assign fq.dec_valid = ~clr & ~fifo_empty;
  assign live         = head;
`endif

  assign push = inflight_valid & ~clr & ~take;
  assign pop  = ~clr & ~fifo_empty & fq.dec_ready;

  // Keep the last presented entry on the outputs while nothing is valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            held <= '0;
    else if (fq.dec_valid) held <= live;
  end

  assign fq.dec_instr = fq.dec_valid ? live.instr : held.instr;
  assign fq.dec_pc    = fq.dec_valid ? live.pc    : held.pc;

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (head),
    .count (count)
  );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench: PC + synchronous instruction memory model feeding instr_fetch_queue.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [ADDR_W-1:0]  pc, load_addr;
  logic [INSTR_W-1:0] rdata;

  instr_fetch_queue_if ifc();

  instr_fetch_queue #(.DEPTH(4)) dut (.clk(clk), .reset(reset), .fq(ifc));

  always #5 clk = ~clk;

  assign ifc.pc_addr   = pc;
  assign ifc.mem_rdata = rdata;

  // PC holds at 0 while start is low; memory returns 16'hA000 + address one cycle later.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc    <= '0;
      rdata <= '0;
    end else begin
      rdata <= 16'hA000 + 16'(ifc.pc_addr);
      if (ifc.flush)          pc <= load_addr;
      else if (!ifc.start)    pc <= '0;
      else if (!ifc.stall_pc) pc <= pc + 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ifc.start = 1'b0; ifc.flush = 1'b0; ifc.dec_ready = 1'b0; load_addr = '0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
  endtask

  // Waits for the next handshake and returns the entry decode accepts; ok=0 on timeout.
  task automatic next_accept(output logic [ADDR_W-1:0] apc, output logic [INSTR_W-1:0] ains,
                             output bit ok);
    ok = 1'b0; apc = '0; ains = '0;
    for (int i = 0; i < 20; i++) begin
      if (ifc.dec_valid && ifc.dec_ready) begin
        apc = ifc.dec_pc; ains = ifc.dec_instr; ok = 1'b1;
        tick();
        return;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ifc.start = 1'b0; ifc.flush = 1'b0; ifc.dec_ready = 1'b0; load_addr = '0;
    #2;
    n_cmp++; if (ifc.stall_pc !== 1'b0) begin n_bad++; $display("FAIL reset stall_pc got %b want 0", ifc.stall_pc); end
    n_cmp++; if (ifc.dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset dec_valid got %b want 0", ifc.dec_valid); end
    n_cmp++; if (ifc.dec_instr !== 16'h0) begin n_bad++; $display("FAIL reset dec_instr got %h want 0", ifc.dec_instr); end
    n_cmp++; if (ifc.dec_pc !== 13'h0) begin n_bad++; $display("FAIL reset dec_pc got %h want 0", ifc.dec_pc); end
  endtask

  task automatic test_stream();
    logic exp_v;
    do_reset();
    ifc.start = 1'b1; ifc.dec_ready = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_v = (k >= LAT);
      n_cmp++; if (ifc.dec_valid !== exp_v) begin n_bad++; $display("FAIL stream valid k=%0d got %b want %b", k, ifc.dec_valid, exp_v); end
      n_cmp++; if (ifc.stall_pc !== 1'b0) begin n_bad++; $display("FAIL stream stall k=%0d got %b want 0", k, ifc.stall_pc); end
      if (exp_v) begin
        n_cmp++; if (ifc.dec_pc !== 13'(k - LAT)) begin n_bad++; $display("FAIL stream pc k=%0d got %h want %h", k, ifc.dec_pc, 13'(k - LAT)); end
        n_cmp++; if (ifc.dec_instr !== 16'hA000 + 16'(k - LAT)) begin n_bad++; $display("FAIL stream instr k=%0d got %h want %h", k, ifc.dec_instr, 16'hA000 + 16'(k - LAT)); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] apc; logic [INSTR_W-1:0] ains; bit ok;
    do_reset();
    ifc.start = 1'b1; ifc.dec_ready = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_cmp++; if (ifc.stall_pc !== (k >= 4)) begin n_bad++; $display("FAIL bp stall k=%0d got %b want %b", k, ifc.stall_pc, (k >= 4)); end
    end
    n_cmp++; if (ifc.dec_valid !== 1'b1 || ifc.dec_pc !== 13'h0) begin n_bad++; $display("FAIL bp head got v=%b pc=%h want v=1 pc=0", ifc.dec_valid, ifc.dec_pc); end
    ifc.dec_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      next_accept(apc, ains, ok);
      n_cmp++; if (!ok || apc !== 13'(i) || ains !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL bp drain i=%0d got ok=%b pc=%h instr=%h want pc=%h", i, ok, apc, ains, 13'(i)); end
    end
  endtask

  task automatic test_push_pop();
    do_reset();
    ifc.start = 1'b1; ifc.dec_ready = 1'b0;
    repeat (4) tick();
    n_cmp++; if (ifc.stall_pc !== 1'b1 || ifc.dec_pc !== 13'h0) begin n_bad++; $display("FAIL pp pre got stall=%b pc=%h want stall=1 pc=0", ifc.stall_pc, ifc.dec_pc); end
    ifc.dec_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      n_cmp++; if (ifc.dec_valid !== 1'b1 || ifc.dec_pc !== 13'(k)) begin n_bad++; $display("FAIL pp head k=%0d got v=%b pc=%h want v=1 pc=%h", k, ifc.dec_valid, ifc.dec_pc, 13'(k)); end
      n_cmp++; if (ifc.stall_pc !== 1'b0) begin n_bad++; $display("FAIL pp stall k=%0d got %b want 0", k, ifc.stall_pc); end
    end
  endtask

  task automatic test_flush();
    logic [ADDR_W-1:0] apc; logic [INSTR_W-1:0] ains; bit ok;
    do_reset();
    ifc.start = 1'b1; ifc.dec_ready = 1'b1;
    repeat (7) tick();
    ifc.dec_ready = 1'b0;
    tick();
    ifc.flush = 1'b1; load_addr = 13'h0100; ifc.dec_ready = 1'b1;
    #1;
    n_cmp++; if (ifc.dec_valid !== 1'b0) begin n_bad++; $display("FAIL flush valid got %b want 0", ifc.dec_valid); end
    tick();
    ifc.flush = 1'b0;
    next_accept(apc, ains, ok);
    n_cmp++; if (!ok || apc !== 13'h0100 || ains !== 16'hA100) begin n_bad++; $display("FAIL flush first got ok=%b pc=%h instr=%h want pc=0100 instr=a100", ok, apc, ains); end
    next_accept(apc, ains, ok);
    n_cmp++; if (!ok || apc !== 13'h0101 || ains !== 16'hA101) begin n_bad++; $display("FAIL flush second got ok=%b pc=%h instr=%h want pc=0101 instr=a101", ok, apc, ains); end
  endtask

  task automatic test_start_drop();
    logic [ADDR_W-1:0] apc; logic [INSTR_W-1:0] ains; bit ok;
    do_reset();
    ifc.start = 1'b1; ifc.dec_ready = 1'b1;
    repeat (5) tick();
    ifc.start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      n_cmp++; if (ifc.dec_valid !== 1'b0 || ifc.stall_pc !== 1'b0) begin n_bad++; $display("FAIL stop k=%0d got v=%b stall=%b want 0 0", k, ifc.dec_valid, ifc.stall_pc); end
    end
    ifc.start = 1'b1;
    for (int i = 0; i < 2; i++) begin
      next_accept(apc, ains, ok);
      n_cmp++; if (!ok || apc !== 13'(i) || ains !== 16'hA000 + 16'(i)) begin n_bad++; $display("FAIL restart i=%0d got ok=%b pc=%h instr=%h want pc=%h", i, ok, apc, ains, 13'(i)); end
    end
  endtask

  task automatic test_async_reset();
    logic [ADDR_W-1:0] apc; logic [INSTR_W-1:0] ains; bit ok;
    do_reset();
    ifc.start = 1'b1; ifc.dec_ready = 1'b0;
    repeat (6) tick();
    n_cmp++; if (ifc.stall_pc !== 1'b1) begin n_bad++; $display("FAIL arst full got stall=%b want 1", ifc.stall_pc); end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (ifc.stall_pc !== 1'b0) begin n_bad++; $display("FAIL arst stall_pc got %b want 0", ifc.stall_pc); end
    n_cmp++; if (ifc.dec_valid !== 1'b0) begin n_bad++; $display("FAIL arst dec_valid got %b want 0", ifc.dec_valid); end
    n_cmp++; if (ifc.dec_instr !== 16'h0 || ifc.dec_pc !== 13'h0) begin n_bad++; $display("FAIL arst dec data got pc=%h instr=%h want 0 0", ifc.dec_pc, ifc.dec_instr); end
    ifc.dec_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    next_accept(apc, ains, ok);
    n_cmp++; if (!ok || apc !== 13'h0 || ains !== 16'hA000) begin n_bad++; $display("FAIL arst restart got ok=%b pc=%h instr=%h want pc=0 instr=a000", ok, apc, ains); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_push_pop();
    test_flush();
    test_start_drop();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/instr_fetch_queue.md
# instr_fetch_queue

Consumer end of the program-counter address stream: tracks each instruction-memory address issued by the PC, captures the synchronous-read data one cycle later, and buffers {pc, instruction} pairs in a small queue for the decode stage. Drives the PC's halt input as back-pressure and squashes wrong-path fetches on a PC load (branch/jump). Sits between the PC/instruction memory and the decode stage of the 16-bit pipeline.

## Interface
- DEPTH, 4, queue entries (power of two, ≥2)
- ADDR_W, 13, instruction address width
- INSTR_W, 16, instruction word width

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  run enable, same signal as the PC's; low = hold block empty
- pc_addr  in  ADDR_W  address the PC presents to instruction memory this cycle
- mem_rdata  in  INSTR_W  instruction memory read data; valid one cycle after its address
- flush  in  1  PC load strobe (same as PC load_enable); current pc_addr is wrong-path
- stall_pc  out  1  to PC halt input; PC must hold its address
- dec_valid  out  1  queue head valid toward decode
- dec_ready  in  1  decode accepts head
- dec_instr  out  INSTR_W  head instruction
- dec_pc  out  ADDR_W  address of head instruction

## Operation
- Issue tracking: registered inflight_valid, inflight_addr. Each edge: inflight_valid <= start & ~flush & ~stall_pc; inflight_addr <= pc_addr.
- A held PC address (stall_pc high) re-reads the same word; it is not issued again and is never enqueued twice.
- Enqueue: at edge, if inflight_valid & ~flush & start, push {inflight_addr, mem_rdata} (unless consumed by bypass, see Configuration).
- Dequeue: at edge, if dec_valid & dec_ready.
- stall_pc = (count + inflight_valid) >= DEPTH; depends on registered state only, no combinational path from dec_ready or flush. Guarantees push never overflows, including simultaneous push/pop.
- flush high: count <= 0, inflight_valid <= 0, pointers reset; dec_valid forced low this cycle (no handshake completes); in-flight word discarded. First correct-path address is the PC's loaded value next cycle.
- start low: identical to flush, held every cycle; stall_pc = 0.
- Order strictly by issue order; dec_pc always the address the instruction was read from.
- Empty: dec_valid = 0; dec_instr/dec_pc hold last driven value (don't-care to decode).

## Timing
- Reset values: stall_pc 0, dec_valid 0, dec_instr 0, dec_pc 0, count 0, inflight_valid 0.
- Address at cycle t, data at t+1; dec_valid for that word at t+2 (t+1 with bypass).
- Steady state with dec_ready high: one instruction per cycle, stall_pc never asserts.
- dec_ready low: queue fills; stall_pc asserts when count + inflight_valid reaches DEPTH; deasserts the cycle after a pop drops the sum below DEPTH.
- Reset mid-operation: all state cleared immediately; no partial entry survives.

## Configuration
- FETCH_BYPASS_EN defined: when count == 0 and inflight_valid & ~flush, dec_valid = 1 combinationally with dec_instr = mem_rdata, dec_pc = inflight_addr; if dec_ready, word is not enqueued. Saves one cycle of fetch latency; adds mem_rdata-to-decode combinational path.
- Undefined: dec_* driven only from queue storage (registered), latency t+2.

## Structure
- Package fetch_pkg: ADDR_W, INSTR_W constants, fetch_entry_t {pc, instr} typedef.
- Sub-module fetch_fifo: DEPTH-entry storage of fetch_entry_t, read/write pointers with wrap, count, synchronous clear; top level holds issue tracking, stall, flush and bypass logic.

## Test plan
- Reset released, start=1, dec_ready=1, PC counting from 0, mem_rdata = 16'hA000+addr -> dec_pc 0,1,2,… one per cycle, dec_instr A000,A001,…, first dec_valid at cycle 2 (1 with FETCH_BYPASS_EN).
- dec_ready=0 for 10 cycles -> stall_pc asserts when count+inflight = 4; exactly 4 entries held (pc 0–3), no duplicates; dec_ready=1 -> pc 0,1,2,3,4 in order.
- flush pulse while queue holds pc 5,6 and pc 7 in flight, PC loads 13'h0100 -> next dec_valid carries dec_pc 0x100; 5,6,7 never presented.
- Simultaneous push and pop at count 3 with dec_ready high -> count stays 3, order preserved, stall_pc behaviour per formula.
- start dropped mid-stream -> dec_valid 0 next cycle, stall_pc 0; start raised with PC at 0 -> stream restarts at pc 0.
- Async reset asserted mid-cycle with full queue -> all outputs to reset values immediately; no stale entry after release.
